// File: rtl/vending_pkg.sv
// Shared definitions for the vending controller: FSM encoding and helpers
// for pulling fixed-width fields out of packed parameter vectors.
package vending_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_VEND   = 2'd1;
    localparam logic [1:0] S_CHANGE = 2'd2;

    // Widest packed parameter vector the field extractor accepts.
    localparam int FIELD_VEC_W = 1024;

    // Index width for an N-entry selector; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Extract field idx of width w from a packed vector (field 0 in the LSBs).
    function automatic int unsigned field_get(input logic [FIELD_VEC_W-1:0] vec,
                                              input int unsigned idx,
                                              input int unsigned w);
        logic [FIELD_VEC_W-1:0] sh;
        sh = vec >> (idx * w);
        return sh[31:0] & ((32'd1 << w) - 32'd1);
    endfunction

    function automatic int unsigned price_at(input logic [FIELD_VEC_W-1:0] prices,
                                             input int unsigned idx,
                                             input int unsigned w);
        return field_get(prices, idx, w);
    endfunction

    function automatic int unsigned coin_at(input logic [FIELD_VEC_W-1:0] coins,
                                            input int unsigned idx,
                                            input int unsigned w);
        return field_get(coins, idx, w);
    endfunction

endpackage

// File: rtl/vend_stock.sv
// Per-item stock counters: bulk reload on restock, single-item decrement on
// purchase (saturating at zero), and a sold-out flag per item.
module vend_stock
    import vending_pkg::*;
#(
    parameter int N_ITEMS    = 5,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 9,
    parameter int IDX_W      = idx_w(N_ITEMS)
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               restock_i,
    input  logic               dec_i,
    input  logic [IDX_W-1:0]   dec_idx_i,
    output logic [N_ITEMS-1:0] soldout_o
);

    logic [N_ITEMS-1:0][STOCK_W-1:0] stock_q, stock_d;

    // Restock overrides any decrement; decrement never wraps below zero.
    always_comb begin
        stock_d = stock_q;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (restock_i)
                stock_d[i] = STOCK_W'(STOCK_INIT);
            else if (dec_i && (dec_idx_i == IDX_W'(i)) && (stock_q[i] != '0))
                stock_d[i] = stock_q[i] - STOCK_W'(1);
        end
    end

    // Counter registers, reloaded to the full level on reset.
    always_ff @(posedge clk) begin
        if (rst) stock_q <= {N_ITEMS{STOCK_W'(STOCK_INIT)}};
        else     stock_q <= stock_d;
    end

    // Sold-out flags decoded straight from the counters.
    always_comb begin
        for (int i = 0; i < N_ITEMS; i++)
            soldout_o[i] = (stock_q[i] == '0);
    end

endmodule

// File: rtl/vending_ctrl_multi.sv
// Vending-machine core: credit register, coin adder, item selection pointer,
// purchase/cancel FSM and ready/valid handoff to dispenser and coin hopper.
module vending_ctrl_multi
    import vending_pkg::*;
#(
    parameter int                         N_ITEMS    = 5,
    parameter int                         PRICE_W    = 5,
    parameter logic [N_ITEMS*PRICE_W-1:0] PRICES     = {5'd8, 5'd10, 5'd6, 5'd5, 5'd7},
    parameter int                         N_COINS    = 4,
    parameter int                         COIN_W     = 5,
    parameter logic [N_COINS*COIN_W-1:0]  COIN_VALS  = {5'd20, 5'd10, 5'd5, 5'd1},
    parameter int                         CREDIT_W   = 7,
    parameter int                         CREDIT_MAX = 99,
    parameter int                         STOCK_W    = 4,
    parameter int                         STOCK_INIT = 9,
    localparam int                        IDX_W      = idx_w(N_ITEMS)
)(
    input  logic                clk,
    input  logic                rst,
    input  logic [N_COINS-1:0]  coin_in,
    input  logic                btn_left,
    input  logic                btn_right,
    input  logic                btn_confirm,
    input  logic                btn_cancel,
    input  logic                restock,
    input  logic                vend_ready,
    input  logic                change_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic [IDX_W-1:0]    sel_idx,
    output logic [PRICE_W-1:0]  sel_price,
    output logic [N_ITEMS-1:0]  avail,
    output logic [N_ITEMS-1:0]  soldout,
    output logic                vend_valid,
    output logic [IDX_W-1:0]    vend_idx,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic                coin_reject,
    output logic                err
);

    logic [1:0]          state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d, change_amt_q, change_amt_d;
    logic [IDX_W-1:0]    sel_q, sel_d, vend_idx_q, vend_idx_d;
    logic                vend_valid_q, vend_valid_d, change_valid_q, change_valid_d;
    logic                coin_reject_q, coin_reject_d, err_q, err_d;
    logic                stock_restock, stock_dec;
    logic [N_ITEMS-1:0]  soldout_w, avail_w;
    logic [N_ITEMS-1:0][PRICE_W-1:0] price_w;
    int unsigned         coin_add, credit_sum;

    vend_stock #(
        .N_ITEMS(N_ITEMS), .STOCK_W(STOCK_W), .STOCK_INIT(STOCK_INIT), .IDX_W(IDX_W)
    ) u_stock (
        .clk(clk), .rst(rst), .restock_i(stock_restock), .dec_i(stock_dec),
        .dec_idx_i(sel_q), .soldout_o(soldout_w)
    );

    // Price table decode and per-item affordability (credit covers it and in stock).
    always_comb begin
        for (int i = 0; i < N_ITEMS; i++) begin
            price_w[i] = PRICE_W'(price_at(FIELD_VEC_W'(PRICES), i, PRICE_W));
            avail_w[i] = (credit_q >= CREDIT_W'(price_w[i])) && !soldout_w[i];
        end
    end

    // Simultaneous coins are summed into one addend.
    always_comb begin
        coin_add = 0;
        for (int c = 0; c < N_COINS; c++)
            if (coin_in[c]) coin_add = coin_add + coin_at(FIELD_VEC_W'(COIN_VALS), c, COIN_W);
        credit_sum = 32'(credit_q) + coin_add;
    end

    // FSM next state: cancel beats confirm beats navigation; coins only credited when idle and unobstructed.
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        sel_d          = sel_q;
        vend_valid_d   = vend_valid_q;
        vend_idx_d     = vend_idx_q;
        change_valid_d = change_valid_q;
        change_amt_d   = change_amt_q;
        coin_reject_d  = 1'b0;
        err_d          = 1'b0;
        stock_restock  = 1'b0;
        stock_dec      = 1'b0;
        case (state_q)
            S_VEND: begin
                coin_reject_d = |coin_in;
                if (vend_ready) begin
                    vend_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            S_CHANGE: begin
                coin_reject_d = |coin_in;
                if (change_ready) begin
                    change_valid_d = 1'b0;
                    state_d        = S_IDLE;
                end
            end
            default: begin
                stock_restock = restock;
                if (btn_cancel) begin
                    if (credit_q != '0) begin
                        change_amt_d   = credit_q;
                        credit_d       = '0;
                        change_valid_d = 1'b1;
                        state_d        = S_CHANGE;
                    end
                end else if (btn_confirm) begin
                    // A coincident restock swallows the purchase.
                    if (!restock) begin
                        if (avail_w[sel_q]) begin
                            credit_d     = credit_q - CREDIT_W'(price_w[sel_q]);
                            stock_dec    = 1'b1;
                            vend_idx_d   = sel_q;
                            vend_valid_d = 1'b1;
                            state_d      = S_VEND;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end else if (btn_left && !btn_right) begin
                    sel_d = (sel_q == '0) ? IDX_W'(N_ITEMS - 1) : sel_q - IDX_W'(1);
                end else if (btn_right && !btn_left) begin
                    sel_d = (sel_q == IDX_W'(N_ITEMS - 1)) ? '0 : sel_q + IDX_W'(1);
                end
                if (|coin_in) begin
                    if (!btn_cancel && !btn_confirm && (credit_sum <= 32'(CREDIT_MAX)))
                        credit_d = CREDIT_W'(credit_sum);
                    else
                        coin_reject_d = 1'b1;
                end
            end
        endcase
    end

    // State and output registers; reset aborts any pending transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            sel_q          <= '0;
            vend_valid_q   <= 1'b0;
            vend_idx_q     <= '0;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
            coin_reject_q  <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            sel_q          <= sel_d;
            vend_valid_q   <= vend_valid_d;
            vend_idx_q     <= vend_idx_d;
            change_valid_q <= change_valid_d;
            change_amt_q   <= change_amt_d;
            coin_reject_q  <= coin_reject_d;
            err_q          <= err_d;
        end
    end

    assign credit       = credit_q;
    assign sel_idx      = sel_q;
    assign sel_price    = price_w[sel_q];
    assign avail        = avail_w;
    assign soldout      = soldout_w;
    assign vend_valid   = vend_valid_q;
    assign vend_idx     = vend_idx_q;
    assign change_valid = change_valid_q;
    assign change_amt   = change_amt_q;
    assign coin_reject  = coin_reject_q;
    assign err          = err_q;

endmodule
